// File: rtl/sram_pkg.sv
// Shared types and constants for the byte-enable simple-dual-port SRAM.
package sram_pkg;

  typedef enum logic [0:0] {
    INIT  = 1'b0,
    READY = 1'b1
  } state_e;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

  function automatic int calc_nbe(input int data_bit, input int byte_bit);
    return data_bit / byte_bit;
  endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// Read-result pipeline: shifts a data/valid pair through RD_LAT register stages.
module sram_rd_pipe #(
  parameter int DATA_BIT = 64,
  parameter int RD_LAT   = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic [DATA_BIT-1:0] in_data,
  output logic                out_valid,
  output logic [DATA_BIT-1:0] out_data
);

  logic [RD_LAT-1:0]   vld;
  logic [DATA_BIT-1:0] dat [RD_LAT];

  // Data stages only load behind a valid, so the output holds between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
      for (int i = 0; i < RD_LAT; i++) dat[i] <= '0;
    end else begin
      vld[0] <= in_valid;
      if (in_valid) dat[0] <= in_data;
      for (int i = 1; i < RD_LAT; i++) begin
        vld[i] <= vld[i-1];
        if (vld[i-1]) dat[i] <= dat[i-1];
      end
    end
  end

  assign out_valid = vld[RD_LAT-1];
  assign out_data  = dat[RD_LAT-1];

endmodule

// File: rtl/sram_sdp_be.sv
// Simple-dual-port SRAM with byte enables, self-clearing init and RD_LAT 1/2.
// Define SRAM_RD_BYPASS_EN for write-first same-address reads (default read-first).
//
// state | meaning
// INIT  | writing zero to mem[cnt], requests ignored
// READY | array cleared, reads and writes accepted
module sram_sdp_be
  import sram_pkg::*;
#(
  parameter int DATA_BIT = 64,
  parameter int ADDR_BIT = 8,
  parameter int BYTE_BIT = 8,
  parameter int RD_LAT   = 1
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     wr_en,
  input  logic [ADDR_BIT-1:0]                      wr_addr,
  input  logic [DATA_BIT-1:0]                      wr_data,
  input  logic [calc_nbe(DATA_BIT, BYTE_BIT)-1:0]  wr_be,
  input  logic                                     rd_en,
  input  logic [ADDR_BIT-1:0]                      rd_addr,
  output logic [DATA_BIT-1:0]                      rd_data,
  output logic                                     rd_valid,
  output logic                                     init_done
);

  localparam int NBE   = calc_nbe(DATA_BIT, BYTE_BIT);
  localparam int DEPTH = 1 << ADDR_BIT;

  localparam logic [0:0] ST_INIT  = 1'(INIT);
  localparam logic [0:0] ST_READY = 1'(READY);

  if (DATA_BIT % BYTE_BIT != 0) begin : g_chk_width
    $fatal(1, "sram_sdp_be: DATA_BIT must be a multiple of BYTE_BIT");
  end
  if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_chk_lat
    $fatal(1, "sram_sdp_be: RD_LAT must be 1 or 2");
  end

  logic [DATA_BIT-1:0] mem [DEPTH];
  logic [0:0]          state;
  logic [0:0]          state_nxt;
  logic [ADDR_BIT-1:0] cnt;
  logic                ready;
  logic                rd_accept;
  logic                wr_accept;
  logic [DATA_BIT-1:0] rd_word;

  assign ready     = (state == ST_READY);
  assign rd_accept = rd_en && ready;
  assign wr_accept = wr_en && ready;
  assign init_done = ready;

  always_comb begin
    state_nxt = state;
    if (state == ST_INIT && cnt == ADDR_BIT'(DEPTH - 1)) state_nxt = ST_READY;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_INIT) cnt <= cnt + 1'b1;
    end
  end

  // No reset on the array: state sits in INIT during reset, so user writes are blocked.
  always_ff @(posedge clk) begin
    if (state == ST_INIT) begin
      mem[cnt] <= '0;
    end else if (wr_accept) begin
      for (int k = 0; k < NBE; k++) begin
        if (wr_be[k]) mem[wr_addr][k*BYTE_BIT +: BYTE_BIT] <= wr_data[k*BYTE_BIT +: BYTE_BIT];
      end
    end
  end

`ifdef SRAM_RD_BYPASS_EN
  always_comb begin
    rd_word = mem[rd_addr];
    if (wr_accept && wr_addr == rd_addr) begin
      for (int k = 0; k < NBE; k++) begin
        if (wr_be[k]) rd_word[k*BYTE_BIT +: BYTE_BIT] = wr_data[k*BYTE_BIT +: BYTE_BIT];
      end
    end
  end
`else
  assign rd_word = mem[rd_addr];
`endif

  sram_rd_pipe #(
    .DATA_BIT (DATA_BIT),
    .RD_LAT   (RD_LAT)
  ) u_rd_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (rd_accept),
    .in_data   (rd_word),
    .out_valid (rd_valid),
    .out_data  (rd_data)
  );

endmodule

// File: tb/tb_sram_sdp_be.sv
// Directed bench for sram_sdp_be: one instance per read latency, shared stimulus.
module tb_sram_sdp_be;

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [63:0] wr_data;
  logic [7:0]  wr_be;
  logic        rd_en;
  logic [7:0]  rd_addr;

  logic [63:0] rd_data1, rd_data2;
  logic        rd_valid1, rd_valid2;
  logic        init_done1, init_done2;

  int n_vec = 0;
  int n_err = 0;

  logic [63:0] model [256];

  sram_sdp_be #(.DATA_BIT(64), .ADDR_BIT(8), .BYTE_BIT(8), .RD_LAT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data1),
    .rd_valid(rd_valid1), .init_done(init_done1)
  );

  sram_sdp_be #(.DATA_BIT(64), .ADDR_BIT(8), .BYTE_BIT(8), .RD_LAT(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data2),
    .rd_valid(rd_valid2), .init_done(init_done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [7:0] a, input logic [63:0] d, input logic [7:0] be);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
    @(negedge clk);
    wr_en = 1'b0;
    for (int k = 0; k < 8; k++) if (be[k]) model[a][k*8 +: 8] = d[k*8 +: 8];
  endtask

  task automatic read_one(input string tag, input logic [7:0] a, input logic [63:0] exp);
    rd_en = 1'b1; rd_addr = a;
    @(negedge clk);
    rd_en = 1'b0;
    chk({tag, "_v1"}, rd_valid1, 1'b1);
    chk({tag, "_d1"}, rd_data1, exp);
    chk({tag, "_v2_early"}, rd_valid2, 1'b0);
    @(negedge clk);
    chk({tag, "_v1_off"}, rd_valid1, 1'b0);
    chk({tag, "_d1_hold"}, rd_data1, exp);
    chk({tag, "_v2"}, rd_valid2, 1'b1);
    chk({tag, "_d2"}, rd_data2, exp);
    @(negedge clk);
    chk({tag, "_v2_off"}, rd_valid2, 1'b0);
  endtask

  task automatic read_burst(input string tag, input int base, input int n);
    for (int i = 0; i < n + 2; i++) begin
      if (i < n) begin
        rd_en = 1'b1; rd_addr = 8'(base + i);
      end else begin
        rd_en = 1'b0;
      end
      @(negedge clk);
      if (i < n) begin
        chk({tag, "_v1"}, rd_valid1, 1'b1);
        chk({tag, "_d1"}, rd_data1, model[base + i]);
      end else begin
        chk({tag, "_v1_off"}, rd_valid1, 1'b0);
      end
      if (i >= 1 && i <= n) begin
        chk({tag, "_v2"}, rd_valid2, 1'b1);
        chk({tag, "_d2"}, rd_data2, model[base + i - 1]);
      end else begin
        chk({tag, "_v2_off"}, rd_valid2, 1'b0);
      end
    end
  endtask

  task automatic run_init(input string tag, input logic poke);
    for (int i = 1; i <= 256; i++) begin
      if (poke && i < 256) begin
        wr_en = 1'b1; wr_addr = 8'h30; wr_data = 64'hDEAD_BEEF_CAFE_F00D; wr_be = 8'hFF;
        rd_en = 1'b1; rd_addr = 8'h30;
      end else begin
        wr_en = 1'b0; rd_en = 1'b0;
      end
      @(negedge clk);
      chk({tag, "_init_done1"}, init_done1, (i == 256));
      chk({tag, "_init_done2"}, init_done2, (i == 256));
      chk({tag, "_no_valid1"}, rd_valid1, 1'b0);
      chk({tag, "_no_valid2"}, rd_valid2, 1'b0);
    end
  endtask

  logic [63:0] coll_exp;

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
    rd_en = 1'b0; rd_addr = '0;
    for (int i = 0; i < 256; i++) model[i] = '0;

    repeat (3) @(negedge clk);
    chk("rst_rd_valid1", rd_valid1, 1'b0);
    chk("rst_rd_valid2", rd_valid2, 1'b0);
    chk("rst_rd_data1", rd_data1, 64'h0);
    chk("rst_rd_data2", rd_data2, 64'h0);
    chk("rst_init_done1", init_done1, 1'b0);

    // Requests during INIT must be ignored, including the write to 0x30.
    rst_n = 1'b1;
    run_init("init", 1'b1);

    read_burst("clr_all", 0, 256);
    read_one("init_wr_ignored", 8'h30, 64'h0);

    do_write(8'h10, 64'h0123_4567_89AB_CDEF, 8'hFF);
    read_one("full_wr", 8'h10, 64'h0123_4567_89AB_CDEF);

    do_write(8'h10, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
    read_one("byte_mask", 8'h10, 64'h0123_4567_FFFF_FFFF);

    do_write(8'h10, 64'h0, 8'h00);
    read_one("be_zero_noop", 8'h10, 64'h0123_4567_FFFF_FFFF);

    // Read and write to different addresses in the same cycle.
    wr_en = 1'b1; wr_addr = 8'h40; wr_data = 64'hA5A5_5A5A_0F0F_F0F0; wr_be = 8'hFF;
    model[8'h40] = 64'hA5A5_5A5A_0F0F_F0F0;
    read_one("diff_addr", 8'h10, 64'h0123_4567_FFFF_FFFF);
    wr_en = 1'b0;
    read_one("diff_addr_wr", 8'h40, 64'hA5A5_5A5A_0F0F_F0F0);

    do_write(8'h20, 64'h1111_1111_1111_1111, 8'hFF);
`ifdef SRAM_RD_BYPASS_EN
    coll_exp = 64'h2222_2222_2222_2222;
`else
    coll_exp = 64'h1111_1111_1111_1111;
`endif
    wr_en = 1'b1; wr_addr = 8'h20; wr_data = 64'h2222_2222_2222_2222; wr_be = 8'hFF;
    read_one("collision_full", 8'h20, coll_exp);
    wr_en = 1'b0;
    read_one("collision_after", 8'h20, 64'h2222_2222_2222_2222);

`ifdef SRAM_RD_BYPASS_EN
    coll_exp = 64'h2222_2222_3333_3333;
`else
    coll_exp = 64'h2222_2222_2222_2222;
`endif
    wr_en = 1'b1; wr_addr = 8'h20; wr_data = 64'h3333_3333_3333_3333; wr_be = 8'h0F;
    read_one("collision_lanes", 8'h20, coll_exp);
    wr_en = 1'b0;
    read_one("collision_lanes_after", 8'h20, 64'h2222_2222_3333_3333);

    for (int i = 0; i < 8; i++) do_write(8'(i), 64'h0101_0101_0101_0101 * 64'(i + 1), 8'hFF);
    read_burst("stream", 0, 8);
    read_burst("top_edge", 252, 4);

    // Reset with two reads in flight in the 2-cycle pipe.
    rd_en = 1'b1; rd_addr = 8'h10;
    @(negedge clk);
    rd_addr = 8'h11;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    rd_en = 1'b0;
    #1;
    chk("midrst_valid1", rd_valid1, 1'b0);
    chk("midrst_valid2", rd_valid2, 1'b0);
    chk("midrst_data1", rd_data1, 64'h0);
    chk("midrst_data2", rd_data2, 64'h0);
    chk("midrst_init_done", init_done1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("midrst_no_late_valid2", rd_valid2, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 256; i++) model[i] = '0;
    run_init("reinit", 1'b0);
    read_one("reinit_cleared", 8'h10, 64'h0);
    read_one("reinit_cleared_40", 8'h40, 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sram_sdp_be.md
Name: sram_sdp_be

Overview:
- Parametrised simple-dual-port SRAM (one write port, one read port) with per-byte write enables and a selectable read latency.
- A self-clearing init sequencer zeroes the whole array after every reset; `init_done` signals readiness.
- Next-generation on-chip buffer for the MMU datapath, replacing single-port, single-direction-per-cycle storage. Reads and writes may occur in the same cycle.

Parameters:
- DATA_BIT, 64, data width in bits; must be an integer multiple of BYTE_BIT (elaboration-time check, fatal otherwise).
- ADDR_BIT, 8, address width; depth DEPTH = 2^ADDR_BIT.
- BYTE_BIT, 8, bits per write-enable lane; NBE = DATA_BIT/BYTE_BIT.
- RD_LAT, 1, read latency in cycles; legal values 1 or 2 (elaboration-time check).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- wr_en  in  1  write request, sampled on posedge clk.
- wr_addr  in  ADDR_BIT  write address.
- wr_data  in  DATA_BIT  write data.
- wr_be  in  NBE  byte enables; bit k covers wr_data[k*BYTE_BIT +: BYTE_BIT].
- rd_en  in  1  read request, sampled on posedge clk.
- rd_addr  in  ADDR_BIT  read address.
- rd_data  out  DATA_BIT  read data, meaningful only while rd_valid=1.
- rd_valid  out  1  one-cycle strobe per accepted read.
- init_done  out  1  array cleared, requests accepted.

Behaviour:
- Reset (async assert): rd_data=0, rd_valid=0, init_done=0, FSM->INIT, clear counter=0, read pipeline flushed. Array contents are not preserved; they are re-cleared after release.
- FSM states: INIT, READY.
- INIT:
  - Each cycle, write all-zero to address cnt; cnt increments.
  - At cnt=DEPTH-1 the final write occurs, then next state is READY.
  - INIT lasts exactly DEPTH cycles after reset release; init_done rises on the first READY cycle.
  - wr_en and rd_en are ignored in INIT: no write, no rd_valid.
- READY:
  - Write: if wr_en=1, for each k with wr_be[k]=1, lane k of mem[wr_addr] is updated at posedge. Lanes with wr_be[k]=0 are unchanged. wr_be=0 with wr_en=1 is a legal no-op.
  - Read: if rd_en=1, the request is accepted.
    - RD_LAT=1: rd_data and rd_valid=1 are driven on the next posedge.
    - RD_LAT=2: one extra register stage is added; the result appears 2 cycles after acceptance.
  - Back-to-back reads are accepted every cycle (fully pipelined, no stall, no backpressure).
  - rd_valid is 1 for exactly one cycle per accepted read. rd_data holds its last value when rd_valid=0; it is not zeroed.
  - READY is left only by reset.
- Simultaneous read and write, different addresses: both complete independently.
- Simultaneous read and write, same address: see Optional Feature.
- Address wrap: none. All addresses 0..DEPTH-1 are valid; the counter wraps only conceptually at the INIT exit.
- Reset mid-operation: in-flight reads are dropped (no rd_valid). Writes at the reset edge are not performed.
- No X propagation on rd_data after reset: the array is always initialised by INIT before any read is accepted.

Optional Feature:
- Macro SRAM_RD_BYPASS_EN.
- Defined: a same-cycle, same-address read returns write-first data. Lanes with wr_be[k]=1 take wr_data; the other lanes take the old mem contents.
- Undefined: read-first. The read returns the pre-write contents; the new data is visible to reads issued on later cycles.
- Latency is RD_LAT in both cases.

Decomposition:
- Package sram_pkg:
  - state enum {INIT, READY};
  - constants RD_LAT_MIN=1, RD_LAT_MAX=2;
  - function computing NBE.
- Sub-module sram_rd_pipe (parameter DATA_BIT, RD_LAT):
  - shifts the data/valid pair through RD_LAT register stages;
  - has an async reset that clears valid and data.

Test Plan:
- Reset release, no requests -> init_done=0 for 256 cycles, =1 on cycle 257; reading every address 0..255 returns 0.
- In READY, write addr 0x10 = 0x0123456789ABCDEF with wr_be=0xFF; read 0x10 next cycle -> rd_valid after RD_LAT cycles with 0x0123456789ABCDEF.
- Byte mask: then write addr 0x10 = 0xFFFFFFFFFFFFFFFF with wr_be=0x0F; read -> 0x01234567FFFFFFFF.
- Collision: mem[0x20]=0x11..11; same cycle write 0x22..22 (wr_be=0xFF) and read 0x20 -> 0x11..11 without the macro, 0x22..22 with SRAM_RD_BYPASS_EN.
- Streaming: rd_en held for 8 cycles over addrs 0..7 -> 8 consecutive rd_valid pulses, in order, starting RD_LAT cycles later; repeat with RD_LAT=2.
- Reset mid-stream: assert rst_n=0 with 2 reads in flight -> rd_valid=0 and rd_data=0 immediately. INIT reruns for 256 cycles; afterwards the previously written addr 0x10 reads 0.
